// File: rtl/pg_burst_ctrl.sv
// Burst / single-shot / continuous run controller for a pulse generator.
// Follows an external period counter (i_cnt vs i_period), arms on a trigger
// edge, gates the channel outputs for whole periods, and times the shadow
// register load strobe so new channel settings take effect at a period
// boundary.
module pg_burst_ctrl #(
  parameter int CNT_W   = 24,
  parameter int BURST_W = 16
) (
  input  logic               i_clk,
  input  logic               i_res_n,
  input  logic [CNT_W-1:0]   i_cnt,
  input  logic [CNT_W-1:0]   i_period,
  input  logic [1:0]         i_mode,
  input  logic [BURST_W-1:0] i_burst_num,
  input  logic [3:0]         i_ch_mask,
  input  logic               i_trig,
  input  logic               i_stop,
  input  logic               i_cfg_upd,
  output logic [3:0]         o_ch_en,
  output logic               o_shadow_ld,
  output logic               o_busy,
  output logic               o_done,
  output logic [BURST_W-1:0] o_per_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_CONT   = 2'd1;
  localparam logic [1:0] MODE_SINGLE = 2'd3;

  state_t             state;
  logic [1:0]         run_mode;   // mode captured at run start
  logic [BURST_W-1:0] remaining;  // periods left including the current one
  logic               stop_pend;
  logic               upd_pend;
  logic               trig_q;

  logic               wrap;
  logic               trig_rise;
  logic               stop_req;
  logic               upd_req;
  logic               last_period;
  logic [BURST_W-1:0] burst_load;

  // Period boundary: the counter sits at its terminal value this cycle.
  assign wrap        = (i_cnt == i_period);
  assign trig_rise   = i_trig & ~trig_q;
  assign stop_req    = i_stop | (i_mode == MODE_OFF);
  assign upd_req     = i_cfg_upd | upd_pend;
  assign last_period = (run_mode != MODE_CONT) && (remaining == BURST_W'(1));
  // A zero burst length still runs one period; single-shot is always one.
  assign burst_load  = ((i_mode == MODE_SINGLE) || (i_burst_num == '0)) ?
                       BURST_W'(1) : i_burst_num;

  // Trigger edge detector history.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      trig_q <= 1'b0;
    end else begin
      // NOTE: sequential state is always assigned with <= so every flop
      // samples the pre-edge values, independent of statement order.
      trig_q <= i_trig;
    end
  end

  // Run sequencing: state, channel gate, busy/done flags and period count.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state     <= S_IDLE;
      run_mode  <= MODE_OFF;
      remaining <= '0;
      stop_pend <= 1'b0;
      o_ch_en   <= '0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
      o_per_cnt <= '0;
    end else begin
      // NOTE: a default at the top of the block turns o_done into a
      // single-cycle strobe; only the terminating branch overrides it.
      o_done <= 1'b0;
      case (state)
        S_IDLE: begin
          o_ch_en <= '0;
          if (trig_rise && (i_mode != MODE_OFF)) begin
            state  <= S_ARM;
            o_busy <= 1'b1;
          end
        end
        S_ARM: begin
          if (stop_req) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
          end else if (wrap) begin
            state     <= S_RUN;
            run_mode  <= i_mode;
            remaining <= burst_load;
            o_per_cnt <= '0;
            o_ch_en   <= i_ch_mask;
          end
        end
        S_RUN: begin
          o_ch_en <= i_ch_mask;
          if (wrap) begin
            if (o_per_cnt != '1) o_per_cnt <= o_per_cnt + 1'b1;
            if (stop_pend || stop_req || last_period) begin
              state     <= S_DONE;
              stop_pend <= 1'b0;
              o_ch_en   <= '0;
              o_busy    <= 1'b0;
              o_done    <= 1'b1;
            end else if (run_mode != MODE_CONT) begin
              remaining <= remaining - 1'b1;
            end
          end else if (stop_req) begin
            stop_pend <= 1'b1;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          stop_pend <= 1'b0;
          o_ch_en   <= '0;
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

  // Shadow load timing: deferred to a period boundary while a run is
  // armed or active, immediate when the generator is quiet.
  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      upd_pend    <= 1'b0;
      o_shadow_ld <= 1'b0;
    end else begin
      if (((state == S_ARM) || (state == S_RUN)) && !wrap) begin
        upd_pend    <= upd_req;
        o_shadow_ld <= 1'b0;
      end else begin
        upd_pend    <= 1'b0;
        o_shadow_ld <= upd_req;
      end
    end
  end

endmodule

// File: tb/tb_pg_burst_ctrl.sv
// Directed bench for pg_burst_ctrl. The bench drives the period counter
// itself, inputs change 1 ns after the rising edge and outputs are sampled
// at the same point, so every sample reflects the state after that edge.
module tb_pg_burst_ctrl;

  logic        i_clk;
  logic        i_res_n;
  logic [23:0] i_cnt;
  logic [23:0] i_period;
  logic [1:0]  i_mode;
  logic [15:0] i_burst_num;
  logic [3:0]  i_ch_mask;
  logic        i_trig;
  logic        i_stop;
  logic        i_cfg_upd;
  logic [3:0]  o_ch_en;
  logic        o_shadow_ld;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_per_cnt;

  int n_cmp;
  int n_fail;

  // Observation results of the last run_obs call.
  int n_en, n_bad_mask, n_done, n_shadow, first_cnt, shadow_cnt, timed_out;

  pg_burst_ctrl #(.CNT_W(24), .BURST_W(16)) dut (
    .i_clk       (i_clk),
    .i_res_n     (i_res_n),
    .i_cnt       (i_cnt),
    .i_period    (i_period),
    .i_mode      (i_mode),
    .i_burst_num (i_burst_num),
    .i_ch_mask   (i_ch_mask),
    .i_trig      (i_trig),
    .i_stop      (i_stop),
    .i_cfg_upd   (i_cfg_upd),
    .o_ch_en     (o_ch_en),
    .o_shadow_ld (o_shadow_ld),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_per_cnt   (o_per_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: advance to just after the edge and step the period counter.
  task automatic tick();
    @(posedge i_clk);
    #1;
    i_cnt = (i_cnt == i_period) ? 24'd0 : i_cnt + 24'd1;
  endtask

  // Run until the controller finishes a run and returns idle, counting
  // gated cycles, done strobes and shadow strobes. Stop / cfg_upd / trig
  // pulses are injected at (period index, count) points; -1 disables one.
  task automatic run_obs(input int max_cyc, input int stop_per, input int stop_c,
                         input int upd_per, input int upd_c1, input int upd_c2,
                         input int trig_per, input int trig_c);
    int per_idx;
    n_en = 0; n_bad_mask = 0; n_done = 0; n_shadow = 0;
    first_cnt = -1; shadow_cnt = -1; timed_out = 1; per_idx = 0;
    for (int k = 0; k < max_cyc; k++) begin
      tick();
      i_trig = 1'b0; i_stop = 1'b0; i_cfg_upd = 1'b0;
      if (o_ch_en != 4'd0) begin
        if (n_en == 0) first_cnt = int'(i_cnt);
        n_en++;
        if (o_ch_en != i_ch_mask) n_bad_mask++;
        if (i_cnt == 24'd0) per_idx++;
      end
      if (o_done) n_done++;
      if (o_shadow_ld) begin
        n_shadow++;
        shadow_cnt = int'(i_cnt);
      end
      if (n_done > 0 && !o_busy && !o_done) begin
        timed_out = 0;
        break;
      end
      if (per_idx == stop_per && int'(i_cnt) == stop_c) i_stop = 1'b1;
      if (per_idx == upd_per && (int'(i_cnt) == upd_c1 || int'(i_cnt) == upd_c2)) i_cfg_upd = 1'b1;
      if (per_idx == trig_per && int'(i_cnt) == trig_c) i_trig = 1'b1;
    end
  endtask

  initial begin
    int cnt_a, cnt_b, cnt_c, seen;
    n_cmp = 0; n_fail = 0;
    i_res_n = 1'b0; i_cnt = 24'd0; i_period = 24'd9; i_mode = 2'd0;
    i_burst_num = 16'd0; i_ch_mask = 4'd0; i_trig = 1'b0; i_stop = 1'b0; i_cfg_upd = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_ch_en", 32'(o_ch_en), 32'd0);
    check("rst_shadow", 32'(o_shadow_ld), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_per_cnt", 32'(o_per_cnt), 32'd0);
    i_res_n = 1'b1;
    repeat (2) tick();

    // cfg_upd while idle: strobe on the following cycle only
    i_cfg_upd = 1'b1;
    tick();
    i_cfg_upd = 1'b0;
    check("idle_shadow_pulse", 32'(o_shadow_ld), 32'd1);
    tick();
    check("idle_shadow_clear", 32'(o_shadow_ld), 32'd0);

    // Burst of 3 x 10 cycles; two cfg_upd in period 2, stray trig in period 2
    i_mode = 2'd2; i_burst_num = 16'd3; i_ch_mask = 4'b0101; i_period = 24'd9;
    i_cnt = 24'd0; i_trig = 1'b1;
    run_obs(200, -1, 0, 2, 2, 5, 2, 7);
    check("burst_timeout", 32'(timed_out), 32'd0);
    check("burst_en_cycles", 32'(n_en), 32'd30);
    check("burst_first_cnt", 32'(first_cnt), 32'd0);
    check("burst_mask", 32'(n_bad_mask), 32'd0);
    check("burst_done_cnt", 32'(n_done), 32'd1);
    check("burst_per_cnt", 32'(o_per_cnt), 32'd3);
    check("burst_shadow_cnt", 32'(n_shadow), 32'd1);
    check("burst_shadow_at", 32'(shadow_cnt), 32'd0);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (o_busy || o_ch_en != 4'd0) seen++;
    end
    check("burst_no_rearm", 32'(seen), 32'd0);

    // Single-shot, period 4, burst_num ignored
    i_mode = 2'd3; i_burst_num = 16'd7; i_ch_mask = 4'b1111; i_period = 24'd4;
    i_cnt = 24'd0; i_trig = 1'b1;
    run_obs(100, -1, 0, -1, 0, 0, -1, 0);
    check("single_timeout", 32'(timed_out), 32'd0);
    check("single_en_cycles", 32'(n_en), 32'd5);
    check("single_per_cnt", 32'(o_per_cnt), 32'd1);
    check("single_done_cnt", 32'(n_done), 32'd1);

    // Burst with burst_num 0 runs one period
    i_mode = 2'd2; i_burst_num = 16'd0; i_ch_mask = 4'b1010;
    i_cnt = 24'd0; i_trig = 1'b1;
    run_obs(100, -1, 0, -1, 0, 0, -1, 0);
    check("burst0_timeout", 32'(timed_out), 32'd0);
    check("burst0_en_cycles", 32'(n_en), 32'd5);
    check("burst0_per_cnt", 32'(o_per_cnt), 32'd1);

    // Continuous, stop pulse at cnt 3 of the 4th period
    i_mode = 2'd1; i_ch_mask = 4'b0011; i_period = 24'd9;
    i_cnt = 24'd0; i_trig = 1'b1;
    run_obs(300, 4, 3, -1, 0, 0, -1, 0);
    check("cont_timeout", 32'(timed_out), 32'd0);
    check("cont_en_cycles", 32'(n_en), 32'd40);
    check("cont_first_cnt", 32'(first_cnt), 32'd0);
    check("cont_per_cnt", 32'(o_per_cnt), 32'd4);
    check("cont_done_cnt", 32'(n_done), 32'd1);

    // Stop while armed: back to idle, no done, gate never opens
    i_mode = 2'd2; i_burst_num = 16'd3; i_ch_mask = 4'b0101;
    i_cnt = 24'd0; i_trig = 1'b1;
    tick();
    i_trig = 1'b0;
    check("arm_busy", 32'(o_busy), 32'd1);
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    check("arm_abort_busy", 32'(o_busy), 32'd0);
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (o_ch_en != 4'd0) cnt_a++;
      if (o_done) cnt_b++;
    end
    check("arm_abort_en", 32'(cnt_a), 32'd0);
    check("arm_abort_done", 32'(cnt_b), 32'd0);

    // Reset mid-burst: outputs drop at once, nothing follows release
    i_cnt = 24'd0; i_trig = 1'b1;
    tick();
    i_trig = 1'b0;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      tick();
      if (o_ch_en != 4'd0) seen = 1;
    end
    check("rstrun_started", 32'(seen), 32'd1);
    repeat (12) tick();
    i_res_n = 1'b0;
    #1;
    check("rstrun_ch_en", 32'(o_ch_en), 32'd0);
    check("rstrun_busy", 32'(o_busy), 32'd0);
    check("rstrun_per_cnt", 32'(o_per_cnt), 32'd0);
    repeat (3) tick();
    i_res_n = 1'b1;
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (o_ch_en != 4'd0) cnt_a++;
      if (o_done) cnt_b++;
      if (o_busy) cnt_c++;
    end
    check("rstrun_after_en", 32'(cnt_a), 32'd0);
    check("rstrun_after_done", 32'(cnt_b), 32'd0);
    check("rstrun_after_busy", 32'(cnt_c), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
